// File: rtl/mem_arbiter_if.sv
// Requester-side and byte-wide RAM-side signal bundle for mem_arbiter.
// The slave modport is the arbiter's view; master is the requesters/RAM view.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              flush_i;
    logic              inst_req_i;
    logic [ADDR_W-1:0] inst_addr_i;
    logic              inst_done_o;
    logic [31:0]       inst_o;
    logic [ADDR_W-1:0] inst_addr_o;
    logic              data_req_i;
    logic              data_wr_i;
    logic [1:0]        data_size_i;
    logic [ADDR_W-1:0] data_addr_i;
    logic [31:0]       data_i;
    logic              data_done_o;
    logic [31:0]       data_o;
    logic              busy_o;
    logic [7:0]        din_ram;
    logic [7:0]        dout_ram;
    logic [ADDR_W-1:0] addr_ram;
    logic              wr_ram;

    modport slave (
        input  flush_i, inst_req_i, inst_addr_i,
        input  data_req_i, data_wr_i, data_size_i, data_addr_i, data_i,
        input  din_ram,
        output inst_done_o, inst_o, inst_addr_o,
        output data_done_o, data_o, busy_o,
        output dout_ram, addr_ram, wr_ram
    );

    modport master (
        output flush_i, inst_req_i, inst_addr_i,
        output data_req_i, data_wr_i, data_size_i, data_addr_i, data_i,
        output din_ram,
        input  inst_done_o, inst_o, inst_addr_o,
        input  data_done_o, data_o, busy_o,
        input  dout_ram, addr_ram, wr_ram
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one byte-wide RAM port between instruction fetch and load/store.
// Data side has priority; a starvation counter forces a fetch grant after STARVE_LIMIT data grants.
module mem_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    localparam int unsigned CNT_W  = $clog2(STARVE_LIMIT + 1) + 1;
    localparam int unsigned BEAT_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        WAIT_LAST
    } state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic                is_inst, is_inst_n;
    logic                is_wr, is_wr_n;
    logic [BEAT_W-1:0]   last, last_n;
    logic [BEAT_W-1:0]   beat, beat_n;
    logic [BEAT_W-1:0]   prev_beat;
    logic [ADDR_W-1:0]   addr_q, addr_n;
    logic [31:0]         wdata_q, wdata_n;
    logic [31:0]         rbuf, rbuf_n;

    logic [ADDR_W-1:0]   addr_ram_q, addr_ram_n;
    logic [7:0]          dout_ram_q, dout_ram_n;
    logic                wr_ram_q, wr_ram_n;
    logic                inst_done_q, inst_done_n;
    logic                data_done_q, data_done_n;
    logic [31:0]         inst_q, inst_n;
    logic [ADDR_W-1:0]   inst_addr_q, inst_addr_n;
    logic [31:0]         data_q, data_n;
    logic                busy_q, busy_n;

    logic                grant_data;
    logic                grant_inst;

    // Index of the last beat: byte, half, word; the illegal size runs as a word.
    function automatic logic [BEAT_W-1:0] size_last(input logic [1:0] size);
        case (size)
            2'b00:   size_last = BEAT_W'(0);
            2'b01:   size_last = BEAT_W'(1);
            default: size_last = BEAT_W'(3);
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            is_inst     <= 1'b0;
            is_wr       <= 1'b0;
            last        <= '0;
            beat        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rbuf        <= '0;
            addr_ram_q  <= '0;
            dout_ram_q  <= '0;
            wr_ram_q    <= 1'b0;
            inst_done_q <= 1'b0;
            data_done_q <= 1'b0;
            inst_q      <= '0;
            inst_addr_q <= '0;
            data_q      <= '0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            is_inst     <= is_inst_n;
            is_wr       <= is_wr_n;
            last        <= last_n;
            beat        <= beat_n;
            addr_q      <= addr_n;
            wdata_q     <= wdata_n;
            rbuf        <= rbuf_n;
            addr_ram_q  <= addr_ram_n;
            dout_ram_q  <= dout_ram_n;
            wr_ram_q    <= wr_ram_n;
            inst_done_q <= inst_done_n;
            data_done_q <= data_done_n;
            inst_q      <= inst_n;
            inst_addr_q <= inst_addr_n;
            data_q      <= data_n;
            busy_q      <= busy_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        is_inst_n   = is_inst;
        is_wr_n     = is_wr;
        last_n      = last;
        beat_n      = beat;
        addr_n      = addr_q;
        wdata_n     = wdata_q;
        rbuf_n      = rbuf;
        addr_ram_n  = addr_ram_q;
        dout_ram_n  = dout_ram_q;
        wr_ram_n    = 1'b0;
        inst_done_n = 1'b0;
        data_done_n = 1'b0;
        inst_n      = inst_q;
        inst_addr_n = inst_addr_q;
        data_n      = data_q;
        prev_beat   = beat - BEAT_W'(1);

        grant_data = bus.data_req_i &&
                     !(bus.inst_req_i && (cnt >= CNT_W'(STARVE_LIMIT)));
        grant_inst = !grant_data && bus.inst_req_i && !bus.flush_i;

        unique case (state)
            IDLE: begin
                if (grant_data || grant_inst) begin
                    state_n    = XFER;
                    beat_n     = '0;
                    rbuf_n     = '0;
                    is_inst_n  = grant_inst;
                    is_wr_n    = grant_data && bus.data_wr_i;
                    addr_n     = grant_data ? bus.data_addr_i : bus.inst_addr_i;
                    last_n     = grant_data ? size_last(bus.data_size_i) : BEAT_W'(3);
                    wdata_n    = bus.data_i;
                    addr_ram_n = addr_n;
                    if (is_wr_n) begin
                        wr_ram_n   = 1'b1;
                        dout_ram_n = bus.data_i[7:0];
                    end
                    // Count data grants that bypass a waiting fetch; a fetch grant clears it.
                    if (grant_data && bus.inst_req_i) begin
                        cnt_n = cnt + CNT_W'(1);
                    end else begin
                        cnt_n = '0;
                    end
                end
            end

            XFER: begin
                if (is_inst && bus.flush_i) begin
                    state_n = IDLE;
                end else begin
                    // RAM data lags the address by one cycle, so capture the previous beat.
                    if (!is_wr && (beat != '0)) begin
                        rbuf_n[{prev_beat, 3'b000} +: 8] = bus.din_ram;
                    end
                    if (beat == last) begin
                        if (is_wr) begin
                            state_n     = IDLE;
                            data_done_n = 1'b1;
                        end else begin
                            state_n = WAIT_LAST;
                        end
                    end else begin
                        beat_n     = beat + BEAT_W'(1);
                        addr_ram_n = addr_q + ADDR_W'(beat_n);
                        if (is_wr) begin
                            wr_ram_n   = 1'b1;
                            dout_ram_n = wdata_q[{beat_n, 3'b000} +: 8];
                        end
                    end
                end
            end

            WAIT_LAST: begin
                state_n = IDLE;
                if (!(is_inst && bus.flush_i)) begin
                    rbuf_n[{last, 3'b000} +: 8] = bus.din_ram;
                    if (is_inst) begin
                        inst_n      = rbuf_n;
                        inst_addr_n = addr_q;
                        inst_done_n = 1'b1;
                    end else begin
                        data_n      = rbuf_n;
                        data_done_n = 1'b1;
                    end
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    assign bus.inst_done_o = inst_done_q;
    assign bus.inst_o      = inst_q;
    assign bus.inst_addr_o = inst_addr_q;
    assign bus.data_done_o = data_done_q;
    assign bus.data_o      = data_q;
    assign bus.busy_o      = busy_q;
    assign bus.dout_ram    = dout_ram_q;
    assign bus.addr_ram    = addr_ram_q;
    assign bus.wr_ram      = wr_ram_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized single transactions
// checked against a byte-array memory model and cycle-latency arithmetic.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total  = 0;
    logic [31:0] exp_inst_o = '0;
    logic [31:0] exp_data_o = '0;

    logic [7:0] ram     [logic [31:0]];
    logic [7:0] ref_mem [logic [31:0]];

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a, input int n);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_rd(a + 32'(i));
        return v;
    endfunction

    function automatic logic [31:0] ram_word(input logic [31:0] a, input int n);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ram_rd(a + 32'(i));
        return v;
    endfunction

    // Synchronous RAM: read data shows the previous cycle's address.
    always @(posedge clk) begin
        bus.din_ram <= ram_rd(bus.addr_ram);
        if (bus.wr_ram) ram[bus.addr_ram] = bus.dout_ram;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [31:0] a, input logic [7:0] v);
        ram[a]     = v;
        ref_mem[a] = v;
    endtask

    task automatic drop_reqs();
        bus.inst_req_i = 1'b0;
        bus.data_req_i = 1'b0;
        bus.flush_i    = 1'b0;
    endtask

    task automatic set_data(input logic wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        bus.data_req_i  = 1'b1;
        bus.data_wr_i   = wr;
        bus.data_size_i = sz;
        bus.data_addr_i = a;
        bus.data_i      = d;
    endtask

    task automatic test_reset();
        bus.din_ram = '0;
        drop_reqs();
        bus.inst_addr_i = '0;
        set_data(1'b0, 2'b00, '0, '0);
        bus.data_req_i = 1'b0;
        rst = 1'b1;
        tick(); tick();
        total++; if ({bus.busy_o, bus.inst_done_o, bus.data_done_o, bus.wr_ram} !== 4'b0)
            $display("FAIL reset_flags: got %b expected 0000", {bus.busy_o, bus.inst_done_o, bus.data_done_o, bus.wr_ram}); else passed++;
        total++; if (bus.addr_ram !== 32'h0 || bus.dout_ram !== 8'h0)
            $display("FAIL reset_ram_port: got addr %h dout %h expected 0", bus.addr_ram, bus.dout_ram); else passed++;
        total++; if ({bus.inst_o, bus.data_o, bus.inst_addr_o} !== 96'h0)
            $display("FAIL reset_results: got %h expected 0", {bus.inst_o, bus.data_o, bus.inst_addr_o}); else passed++;
        rst = 1'b0;
        tick();
        // Reset during beat 2 of a word load.
        set_data(1'b0, 2'b10, 32'h40, '0);
        tick(); tick(); tick();
        total++; if (bus.addr_ram !== 32'h42)
            $display("FAIL midread_beat2_addr: got %h expected 00000042", bus.addr_ram); else passed++;
        rst = 1'b1;
        bus.data_req_i = 1'b0;
        tick();
        rst = 1'b0;
        total++; if ({bus.busy_o, bus.data_done_o, bus.wr_ram} !== 3'b0 || bus.addr_ram !== 32'h0 || bus.data_o !== 32'h0)
            $display("FAIL midread_reset_state: got busy/done/wr %b addr %h data %h expected zeros",
                     {bus.busy_o, bus.data_done_o, bus.wr_ram}, bus.addr_ram, bus.data_o); else passed++;
        begin
            int dones;
            dones = 0;
            for (int k = 0; k < 6; k++) begin tick(); if (bus.data_done_o) dones++; end
            total++; if (dones != 0) $display("FAIL midread_no_done: got %0d pulses expected 0", dones); else passed++;
        end
        exp_data_o = '0;
    endtask

    task automatic test_fetch();
        logic [31:0] got_addr [1:4];
        int done_k;
        poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'h00); poke(32'h103, 8'h00);
        bus.inst_req_i  = 1'b1;
        bus.inst_addr_i = 32'h100;
        done_k = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k <= 4) got_addr[k] = bus.addr_ram;
            if (bus.inst_done_o) begin
                if (done_k == 0) done_k = k;
                bus.inst_req_i = 1'b0;
            end
        end
        bus.inst_req_i = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            total++; if (got_addr[k] !== 32'h100 + 32'(k - 1))
                $display("FAIL fetch_beat_addr%0d: got %h expected %h", k, got_addr[k], 32'h100 + 32'(k - 1)); else passed++;
        end
        total++; if (done_k != 6) $display("FAIL fetch_latency: got %0d expected 6", done_k); else passed++;
        exp_inst_o = 32'h0000_0513;
        total++; if (bus.inst_o !== exp_inst_o || bus.inst_addr_o !== 32'h100)
            $display("FAIL fetch_result: got %h @%h expected 00000513 @00000100", bus.inst_o, bus.inst_addr_o); else passed++;
    endtask

    task automatic test_store_half();
        logic [7:0]  dout [1:3];
        logic [31:0] addr [1:3];
        logic        wr   [1:3];
        logic        done [1:3];
        set_data(1'b1, 2'b01, 32'h2000, 32'h1234_BEEF);
        for (int k = 1; k <= 3; k++) begin
            tick();
            dout[k] = bus.dout_ram; addr[k] = bus.addr_ram; wr[k] = bus.wr_ram; done[k] = bus.data_done_o;
            if (bus.data_done_o) bus.data_req_i = 1'b0;
        end
        bus.data_req_i = 1'b0;
        ref_mem[32'h2000] = 8'hEF; ref_mem[32'h2001] = 8'hBE;
        total++; if ({wr[1], addr[1], dout[1]} !== {1'b1, 32'h2000, 8'hEF})
            $display("FAIL store_beat0: got wr %b addr %h dout %h expected 1 00002000 ef", wr[1], addr[1], dout[1]); else passed++;
        total++; if ({wr[2], addr[2], dout[2]} !== {1'b1, 32'h2001, 8'hBE})
            $display("FAIL store_beat1: got wr %b addr %h dout %h expected 1 00002001 be", wr[2], addr[2], dout[2]); else passed++;
        total++; if ({done[1], done[2], done[3], wr[3]} !== 4'b0010)
            $display("FAIL store_done_cycle: got done %b%b%b wr %b expected 001 0", done[1], done[2], done[3], wr[3]); else passed++;
        tick();
        total++; if (bus.wr_ram !== 1'b0 || ram_word(32'h2000, 2) !== 32'h0000_BEEF || bus.data_o !== exp_data_o)
            $display("FAIL store_after: got wr %b mem %h data_o %h expected 0 0000beef %h",
                     bus.wr_ram, ram_word(32'h2000, 2), bus.data_o, exp_data_o); else passed++;
    endtask

    // Runs one data transaction alone and returns the cycle (after grant) of its done pulse.
    task automatic run_one_data(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                                input logic [31:0] d, output int done_k, output logic [1:0] kinds,
                                output logic [31:0] addr_at_done, output logic [31:0] addr_beat0);
        set_data(wr, sz, a, d);
        done_k = 0; kinds = 2'b00; addr_at_done = '0; addr_beat0 = '0;
        for (int k = 1; k <= 12 && done_k == 0; k++) begin
            tick();
            if (k == 1) addr_beat0 = bus.addr_ram;
            if (bus.inst_done_o || bus.data_done_o) begin
                done_k = k; kinds = {bus.inst_done_o, bus.data_done_o}; addr_at_done = bus.addr_ram;
                bus.data_req_i = 1'b0;
            end
        end
        bus.data_req_i = 1'b0;
    endtask

    task automatic test_wrap();
        int dk; logic [1:0] kd; logic [31:0] ad, a0;
        poke(32'hFFFF_FFFF, 8'h80); poke(32'hFFFF_FFFE, 8'h33); poke(32'h0, 8'h11); poke(32'h1, 8'h22);
        run_one_data(1'b0, 2'b00, 32'hFFFF_FFFF, '0, dk, kd, ad, a0);
        exp_data_o = 32'h0000_0080;
        total++; if (dk != 3 || bus.data_o !== exp_data_o)
            $display("FAIL wrap_byte_load: got %h at %0d expected 00000080 at 3", bus.data_o, dk); else passed++;
        run_one_data(1'b0, 2'b10, 32'hFFFF_FFFE, '0, dk, kd, ad, a0);
        exp_data_o = 32'h2211_8033;
        total++; if (dk != 6 || bus.data_o !== exp_data_o || ad !== 32'h1)
            $display("FAIL wrap_word_load: got %h at %0d last addr %h expected 22118033 at 6 addr 00000001",
                     bus.data_o, dk, ad); else passed++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int kind, nb, lat, dk;
            logic [1:0] sz, kd;
            logic [31:0] a, d, expv, ad, a0;
            kind = int'($urandom_range(0, 2));
            a  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                             : 32'h3000 + 32'($urandom_range(0, 63));
            sz = 2'($urandom_range(0, 3));
            d  = $urandom;
            nb = (kind == 0) ? 4 : (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
            lat = (kind == 2) ? nb + 1 : nb + 2;
            expv = ref_word(a, nb);
            if (kind == 0) begin
                bus.inst_req_i = 1'b1; bus.inst_addr_i = a;
                dk = 0; kd = 2'b00; ad = '0; a0 = '0;
                for (int k = 1; k <= 12 && dk == 0; k++) begin
                    tick();
                    if (k == 1) a0 = bus.addr_ram;
                    if (bus.inst_done_o || bus.data_done_o) begin
                        dk = k; kd = {bus.inst_done_o, bus.data_done_o}; ad = bus.addr_ram;
                        bus.inst_req_i = 1'b0;
                    end
                end
                bus.inst_req_i = 1'b0;
                exp_inst_o = expv;
            end else begin
                run_one_data(kind == 2, sz, a, d, dk, kd, ad, a0);
                if (kind == 1) exp_data_o = expv;
                else for (int i = 0; i < nb; i++) ref_mem[a + 32'(i)] = d[8*i +: 8];
            end
            total++; if (dk != lat || kd !== ((kind == 0) ? 2'b10 : 2'b01))
                $display("FAIL rand%0d_done: got cycle %0d pulses %b expected cycle %0d kind %0d", n, dk, kd, lat, kind); else passed++;
            total++; if (a0 !== a || ad !== a + 32'(nb - 1) || bus.wr_ram !== 1'b0)
                $display("FAIL rand%0d_port: got first %h last %h wr %b expected %h %h 0", n, a0, ad, bus.wr_ram, a, a + 32'(nb - 1)); else passed++;
            total++; if (bus.inst_o !== exp_inst_o || bus.data_o !== exp_data_o || ram_word(a, nb) !== ref_word(a, nb))
                $display("FAIL rand%0d_value: got inst %h data %h mem %h expected %h %h %h", n, bus.inst_o, bus.data_o,
                         ram_word(a, nb), exp_inst_o, exp_data_o, ref_word(a, nb)); else passed++;
        end
    endtask

    // Both requests held: every fifth grant must go to fetch, with no idle cycles between.
    task automatic test_starvation();
        int ndone, last_k;
        logic [31:0] dexp, iexp;
        dexp = ref_word(32'h3100, 1);
        iexp = ref_word(32'h3200, 4);
        set_data(1'b0, 2'b00, 32'h3100, '0);
        bus.inst_req_i = 1'b1; bus.inst_addr_i = 32'h3200;
        ndone = 0; last_k = 0;
        for (int k = 1; k <= 80 && ndone < 10; k++) begin
            tick();
            if (bus.inst_done_o || bus.data_done_o) begin
                logic is_i;
                is_i = (ndone % 5) == 4;
                total++; if ({bus.inst_done_o, bus.data_done_o} !== (is_i ? 2'b10 : 2'b01) || k - last_k != (is_i ? 6 : 3))
                    $display("FAIL starve_grant%0d: got pulses %b gap %0d expected %s gap %0d", ndone,
                             {bus.inst_done_o, bus.data_done_o}, k - last_k, is_i ? "inst" : "data", is_i ? 6 : 3); else passed++;
                total++; if (is_i ? (bus.inst_o !== iexp) : (bus.data_o !== dexp))
                    $display("FAIL starve_value%0d: got %h expected %h", ndone, is_i ? bus.inst_o : bus.data_o, is_i ? iexp : dexp); else passed++;
                ndone++; last_k = k;
                if (ndone == 10) drop_reqs();
            end
        end
        drop_reqs();
        exp_inst_o = iexp; exp_data_o = dexp;
        total++; if (ndone != 10) $display("FAIL starve_count: got %0d grants expected 10", ndone); else passed++;
        tick();
    endtask

    task automatic test_flush();
        int dk, idone; logic [1:0] kd; logic [31:0] ad, a0;
        // Flush at fetch beat 1, data load waiting.
        bus.inst_req_i = 1'b1; bus.inst_addr_i = 32'h180;
        tick(); tick();
        bus.flush_i = 1'b1;
        set_data(1'b0, 2'b00, 32'h2000, '0);
        tick();
        total++; if (bus.busy_o !== 1'b0 || bus.inst_done_o !== 1'b0)
            $display("FAIL flush_abort_idle: got busy %b inst_done %b expected 0 0", bus.busy_o, bus.inst_done_o); else passed++;
        bus.flush_i = 1'b0; bus.inst_req_i = 1'b0;
        tick();
        total++; if (bus.busy_o !== 1'b1) $display("FAIL flush_data_grant: got busy %b expected 1", bus.busy_o); else passed++;
        dk = 0; idone = 0;
        for (int k = 5; k <= 12 && dk == 0; k++) begin
            tick();
            if (bus.inst_done_o) idone++;
            if (bus.data_done_o) begin dk = k; bus.data_req_i = 1'b0; end
        end
        bus.data_req_i = 1'b0;
        exp_data_o = 32'h0000_00EF;
        total++; if (dk != 6 || idone != 0 || bus.data_o !== exp_data_o || bus.inst_o !== exp_inst_o)
            $display("FAIL flush_then_load: got done %0d inst pulses %0d data %h inst %h expected 6 0 000000ef %h",
                     dk, idone, bus.data_o, bus.inst_o, exp_inst_o); else passed++;
        // Flush in the last read cycle suppresses the done pulse.
        bus.inst_req_i = 1'b1; bus.inst_addr_i = 32'h100;
        for (int k = 0; k < 5; k++) tick();
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0; bus.inst_req_i = 1'b0;
        total++; if (bus.inst_done_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.inst_o !== exp_inst_o)
            $display("FAIL flush_last_cycle: got done %b busy %b inst %h expected 0 0 %h",
                     bus.inst_done_o, bus.busy_o, bus.inst_o, exp_inst_o); else passed++;
        // Flush in the grant cycle suppresses the fetch grant.
        bus.inst_req_i = 1'b1; bus.flush_i = 1'b1;
        tick();
        total++; if (bus.busy_o !== 1'b0) $display("FAIL flush_grant: got busy %b expected 0", bus.busy_o); else passed++;
        bus.inst_req_i = 1'b0;
        // Stores ignore flush.
        bus.flush_i = 1'b1;
        run_one_data(1'b1, 2'b10, 32'h2100, 32'hCAFE_F00D, dk, kd, ad, a0);
        bus.flush_i = 1'b0;
        for (int i = 0; i < 4; i++) ref_mem[32'h2100 + 32'(i)] = 8'(32'hCAFE_F00D >> (8 * i));
        total++; if (dk != 5 || kd !== 2'b01 || ram_word(32'h2100, 4) !== ref_word(32'h2100, 4))
            $display("FAIL flush_store: got done %0d pulses %b mem %h expected 5 01 %h", dk, kd,
                     ram_word(32'h2100, 4), ref_word(32'h2100, 4)); else passed++;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store_half();
        test_wrap();
        test_random();
        test_starvation();
        test_flush();
        tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
